sha256_stream_host: RTL
=======================

// Module: sha256_stream_host
// PURPOSE
//  Host-side partner of the byte-serial SHA-256 core. Buffers a single-block message written byte-wise,
//  streams it into the core as one contiguous valid burst, and collects the 32 serial digest bytes.
//  Assembles the digest into a register file readable by byte address, flagging overflow/timeout/short.
//  Sits between the system byte bus and the hash core's data_in/valid_in and hash_out/valid_o pins.
// PARAMETERS
//  MAX_BYTES       55    message bytes buffered (single 64-byte block incl. padding); count width 6
//  TIMEOUT_CYCLES  1023  cycles waited in WAIT for the first digest byte before err_timeout
//  DIGEST_BYTES    32    digest bytes captured; rd_addr width 5
// PORTS
//  clk             in   1  rising-edge clock
//  reset_n         in   1  asynchronous active-low reset
//  wr_data         in   8  message byte to buffer
//  wr_en           in   1  write wr_data at buf[buf_count]
//  start           in   1  launch hashing of buffered message (1-cycle pulse)
//  clear           in   1  synchronous abort/flush
//  core_data       out  8  to core data_in
//  core_valid      out  1  to core valid_in
//  core_hash       in   8  from core hash_out
//  core_hash_valid in   1  from core valid_o
//  rd_addr         in   5  digest byte select, 0 = most significant byte of H0
//  rd_data         out  8  combinational digest[rd_addr]
//  buf_count       out  6  bytes currently buffered
//  busy            out  1  high in SEND, WAIT, CAPTURE
//  done            out  1  level, high in DONE
//  err             out  3  sticky {ovf, short, timeout}
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; core_data=0, core_valid=0, buf_count=0, digest[*]=0, busy=0,
//   done=0, err=0, timer=0, byte index=0. Reset mid-operation aborts immediately; core_valid low at once.
//  All outputs except rd_data registered. States IDLE, SEND, WAIT, CAPTURE, DONE.
//  IDLE/DONE: wr_en with buf_count<MAX_BYTES stores byte, buf_count+1; at MAX_BYTES byte dropped, err[2]=1.
//   wr_en in SEND/WAIT/CAPTURE ignored, no flag.
//  start in IDLE/DONE with buf_count>0: clear err[1:0], digest index=0, done=0 -> SEND. digest[*] retained
//   until overwritten. start with buf_count==0, or while busy: ignored.
//  SEND: core_valid=1 for exactly buf_count consecutive cycles, first rising the cycle after start,
//   core_data=buf[0..n-1] in order; no gaps. Cycle after last byte: core_valid=0, core_data=0 -> WAIT, timer=0.
//   core_hash_valid during SEND ignored.
//  WAIT: timer+1 per cycle; core_hash_valid=1 -> store core_hash at digest[0], index=1 -> CAPTURE.
//   timer reaching TIMEOUT_CYCLES without a byte -> err[0]=1 -> DONE.
//  CAPTURE: each cycle core_hash_valid=1 stores core_hash at digest[index], index+1; byte sampled same
//   cycle valid is high. index reaching DIGEST_BYTES -> DONE. core_hash_valid low with index<32 -> err[1]=1
//   -> DONE; remaining digest bytes keep prior values. Bytes after DONE ignored.
//  DONE: done=1; buffer retained, so start re-hashes same message; new writes append.
//  clear (any state, highest priority after reset): buf_count=0, err=0, done=0, core_valid=0 next cycle
//   -> IDLE; truncates an in-flight SEND. digest[*] not cleared. clear+start same cycle: clear wins.
//  wr_en+start same cycle in IDLE: byte stored, start sees pre-write buf_count (new byte is sent).
//  Widths: buf_count and timer saturate, never wrap; index 6 bits internally, compared to DIGEST_BYTES.
// TESTING
//  Write 61,62,63; start; core model returns ba 78 16 bf ... 20 00 15 ad -> core_valid 3 cycles with
//   61,62,63; done=1, err=0; rd_addr 0->ba, 3->bf, 31->ad.
//  Write 56 bytes (MAX_BYTES=55) -> buf_count=55, err=3'b100; start streams 55 bytes, byte 56 absent.
//  Start, core silent -> exactly TIMEOUT_CYCLES cycles after WAIT entry done=1, err=3'b001, busy=0.
//  Core returns 16 bytes then drops valid_o -> done=1, err=3'b010, digest[16..31] unchanged from prior.
//  start with empty buffer -> no core_valid, state IDLE; clear during SEND byte 2 of 5 -> core_valid low
//   next cycle, buf_count=0, IDLE.
//  reset_n low during CAPTURE -> core_valid=0, done=0, digest all 0 asynchronously; rd_data=00.

Source files
------------

// File: rtl/sha256_stream_host.sv
// rtl/sha256_stream_host.sv - Host-side buffer/streamer/digest collector for a byte-serial SHA-256 core.
// A message is buffered byte-wise, then sent to the core as one gapless burst, and the 32 digest bytes are captured.
module sha256_stream_host #(
    parameter int MAX_BYTES      = 55,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int DIGEST_BYTES   = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       start,
    input  logic       clear,
    output logic [7:0] core_data,
    output logic       core_valid,
    input  logic [7:0] core_hash,
    input  logic       core_hash_valid,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [5:0] buf_count,
    output logic       busy,
    output logic       done,
    output logic [2:0] err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]    MAX_CNT  = 6'(MAX_BYTES);
    localparam logic [5:0]    DIG_CNT  = 6'(DIGEST_BYTES);
    localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = '1;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CAPTURE, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    buf_q [MAX_BYTES];
    logic [7:0]    buf_d [MAX_BYTES];
    logic [7:0]    digest_q [DIGEST_BYTES];
    logic [7:0]    digest_d [DIGEST_BYTES];
    logic [5:0]    buf_count_q, buf_count_d;
    logic [5:0]    send_idx_q, send_idx_d;
    logic [5:0]    dig_idx_q, dig_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    core_data_q, core_data_d;
    logic          core_valid_q, core_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    err_q, err_d;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        digest_d     = digest_q;
        buf_count_d  = buf_count_q;
        send_idx_d   = send_idx_q;
        dig_idx_d    = dig_idx_q;
        timer_d      = timer_q;
        core_data_d  = core_data_q;
        core_valid_d = core_valid_q;
        err_d        = err_q;
        if (clear) begin
            state_d      = IDLE;
            buf_count_d  = '0;
            err_d        = '0;
            core_valid_d = 1'b0;
            core_data_d  = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (wr_en) begin
                        if (buf_count_q < MAX_CNT) begin
                            buf_d[buf_count_q] = wr_data;
                            buf_count_d        = buf_count_q + 6'd1;
                        end else begin
                            err_d[2] = 1'b1;
                        end
                    end
                    // Launch decision uses the pre-write count; a same-cycle write still joins the burst.
                    if (start && buf_count_q != 6'd0) begin
                        err_d[1:0]   = 2'b00;
                        dig_idx_d    = '0;
                        send_idx_d   = 6'd1;
                        core_valid_d = 1'b1;
                        core_data_d  = buf_q[0];
                        state_d      = SEND;
                    end
                end
                SEND: begin
                    if (send_idx_q < buf_count_q) begin
                        core_data_d = buf_q[send_idx_q];
                        send_idx_d  = send_idx_q + 6'd1;
                    end else begin
                        core_valid_d = 1'b0;
                        core_data_d  = '0;
                        timer_d      = '0;
                        state_d      = WAIT;
                    end
                end
                WAIT: begin
                    if (core_hash_valid) begin
                        digest_d[0] = core_hash;
                        dig_idx_d   = 6'd1;
                        state_d     = CAPTURE;
                    end else begin
                        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
                        if (timer_q + 1'b1 == TO_CNT) begin
                            err_d[0] = 1'b1;
                            state_d  = DONE;
                        end
                    end
                end
                CAPTURE: begin
                    if (core_hash_valid) begin
                        digest_d[dig_idx_q[4:0]] = core_hash;
                        dig_idx_d                = dig_idx_q + 6'd1;
                        if (dig_idx_q + 6'd1 == DIG_CNT) state_d = DONE;
                    end else begin
                        err_d[1] = 1'b1;
                        state_d  = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == SEND) || (state_d == WAIT) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            buf_count_q  <= '0;
            send_idx_q   <= '0;
            dig_idx_q    <= '0;
            timer_q      <= '0;
            core_data_q  <= '0;
            core_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
            for (int i = 0; i < DIGEST_BYTES; i++) digest_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            buf_count_q  <= buf_count_d;
            send_idx_q   <= send_idx_d;
            dig_idx_q    <= dig_idx_d;
            timer_q      <= timer_d;
            core_data_q  <= core_data_d;
            core_valid_q <= core_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            digest_q     <= digest_d;
        end
    end

    // Message storage needs no reset: only entries below buf_count are ever read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign core_data  = core_data_q;
    assign core_valid = core_valid_q;
    assign buf_count  = buf_count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rd_data    = digest_q[rd_addr];
endmodule
